// File: rtl/hamming_stream_encoder.sv
// hamming_stream_encoder
//   Iterative Hamming(31,26) encoder. A data word is accepted over a
//   valid/ready handshake. Codeword positions 1..31 are then scanned at one
//   per cycle to build the parity syndrome. The result is presented as a
//   32-bit codeword in which position p sits at bit index 31-p and bit 31 is
//   always 0. An optional single-bit error can be injected into the
//   codeword after encoding.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : data word offered
//   in_ready   : encoder can accept a word (IDLE only)
//   data_in    : data word; bit 25 maps to the lowest data position (3)
//   inj_pos    : position to flip after encoding, 0 = none; sampled with data_in
//   out_valid  : codeword available
//   out_ready  : downstream accepts codeword
//   code_out   : codeword, position p at bit 31-p, bit 31 = 0
//   parity_out : clean syndrome, bit k = parity bit at position 2**k
module hamming_stream_encoder #(
  parameter  int P      = 5,
  localparam int DATA_W = 2**P - 1 - P,
  localparam int CODE_W = 2**P - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [P-1:0]      inj_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W:0]   code_out,
  output logic [P-1:0]      parity_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [P-1:0] LAST_POS = CODE_W[P-1:0];

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [P-1:0]        inj_q, inj_d;
  logic [P-1:0]        syn_q, syn_d;
  logic [P-1:0]        pos_q, pos_d;
  logic [CODE_W:0]     cw_q, cw_d;
  logic [CODE_W:0]     code_out_q, code_out_d;
  logic [P-1:0]        parity_out_q, parity_out_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;

  // Scratch values for the current SCAN/FINAL cycle.
  logic                is_parity_pos;
  logic                data_bit;
  logic [P-1:0]        pos_idx;
  logic [P-1:0]        inj_idx;
  logic [CODE_W:0]     cw_final;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    inj_d        = inj_q;
    syn_d        = syn_q;
    pos_d        = pos_q;
    cw_d         = cw_q;
    code_out_d   = code_out_q;
    parity_out_d = parity_out_q;
    out_valid_d  = out_valid_q;
    in_ready_d   = in_ready_q;

    // A position is a parity slot when it is a power of two.
    is_parity_pos = ((pos_q & (pos_q - 1'b1)) == '0);
    data_bit      = is_parity_pos ? 1'b0 : data_q[DATA_W-1];
    pos_idx       = LAST_POS - pos_q;
    inj_idx       = LAST_POS - inj_q;
    cw_final      = cw_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d     = data_in;
          inj_d      = inj_pos;
          syn_d      = '0;
          pos_d      = {{(P-1){1'b0}}, 1'b1};
          cw_d       = '0;
          in_ready_d = 1'b0;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        // Data bits are consumed MSB-first from a shift register, so the
        // next data bit is always data_q's top bit at every data position.
        if (!is_parity_pos) begin
          data_d = data_q << 1;
          if (data_bit) syn_d = syn_q ^ pos_q;
        end
        cw_d[pos_idx] = data_bit;
        pos_d         = pos_q + 1'b1;
        if (pos_q == LAST_POS) state_d = FINAL;
      end

      FINAL: begin
        for (int unsigned k = 0; k < P; k++) begin
          cw_final[CODE_W - (2**k)] = syn_q[k];
        end
        // Injection is applied after parity insertion and never alters parity_out.
        if (inj_q != '0) cw_final[inj_idx] = ~cw_final[inj_idx];
        code_out_d   = cw_final;
        parity_out_d = syn_q;
        out_valid_d  = 1'b1;
        state_d      = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      inj_q        <= '0;
      syn_q        <= '0;
      pos_q        <= '0;
      cw_q         <= '0;
      code_out_q   <= '0;
      parity_out_q <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      inj_q        <= inj_d;
      syn_q        <= syn_d;
      pos_q        <= pos_d;
      cw_q         <= cw_d;
      code_out_q   <= code_out_d;
      parity_out_q <= parity_out_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign code_out   = code_out_q;
  assign parity_out = parity_out_q;

endmodule
